// File: rtl/avgpool_div_arbiter_pkg.sv
// Shared constants, types and the round-robin search for the pooling divide arbiter.
// Imported by the interface, the arbiter, the Divider and the top level.
package avgpool_div_arbiter_pkg;

   localparam int ARITH_FIXED        = 1;
   localparam int ARITH_FLOAT        = 0;
   localparam int DATA_WIDTH_DEFAULT = 32;

   localparam logic [31:0] FLOAT_QUARTER = 32'h3E800000;

   // Arbiter search is sized for the largest supported lane count.
   localparam int RR_MAX   = 8;
   localparam int RR_IDX_W = 3;

   typedef struct packed {
      logic                hit;
      logic [RR_IDX_W-1:0] idx;
   } rr_grant_t;

   // First requesting lane after `last`, wrapping modulo num_req.
   function automatic rr_grant_t rr_next_grant(input logic [RR_MAX-1:0]   valid,
                                               input logic [RR_IDX_W-1:0] last,
                                               input int                  num_req);
      rr_grant_t g;
      int        j;
      g = '0;
      for (int k = 1; k <= RR_MAX; k++) begin
         if (k <= num_req && !g.hit) begin
            j = (int'(last) + k) % num_req;
            if (valid[j[RR_IDX_W-1:0]]) begin
               g.hit = 1'b1;
               g.idx = j[RR_IDX_W-1:0];
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/avgpool_div_arbiter_if.sv
// Lane request bus plus result bus of the shared pooling divider.
// master = lanes/downstream side, slave = the arbiter.
interface avgpool_div_arbiter_if
   import avgpool_div_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int ID_WIDTH   = 2
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [ID_WIDTH-1:0]           out_id;
   logic [15:0]                   done_count;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, done_count
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, done_count
   );
endinterface

// File: rtl/Divider.sv
// Divide-by-4 scaler: arithmetic shift for fixed point, multiply by 0.25 for IEEE-754 single.
// Purely combinational; the surrounding pipeline provides the registers.
module Divider
   import avgpool_div_arbiter_pkg::*;
#(
   parameter int ARITH_TYPE = ARITH_FIXED,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic [DATA_WIDTH-1:0] operand,
   output logic [DATA_WIDTH-1:0] result
);

   generate
      if (ARITH_TYPE == ARITH_FIXED) begin : g_fixed
         logic signed [DATA_WIDTH-1:0] op_s;
         assign op_s   = operand;
         assign result = op_s >>> 2;
      end else begin : g_float
         // 0.25 is an exact power of two: normals only lose exponent, subnormal results need RNE.
         localparam logic [7:0] Q_DEC = 8'd127 - FLOAT_QUARTER[30:23];

         logic        sign;
         logic [7:0]  exp_in;
         logic [23:0] mant;
         logic [23:0] kept;
         logic        guard;
         logic        sticky;
         logic        round_up;
         logic [30:0] mag;

         always_comb begin
            sign     = operand[31];
            exp_in   = operand[30:23];
            mant     = {exp_in != 8'd0, operand[22:0]};
            kept     = '0;
            guard    = 1'b0;
            sticky   = 1'b0;
            round_up = 1'b0;
            mag      = operand[30:0];
            if (exp_in == 8'hFF) begin
               mag = operand[30:0];
            end else if (exp_in > Q_DEC) begin
               mag = {exp_in - Q_DEC, operand[22:0]};
            end else begin
               // Result lands in the subnormal range; a carry out of rounding becomes the min normal.
               if (exp_in == 8'd2) begin
                  kept   = mant >> 1;
                  guard  = mant[0];
                  sticky = 1'b0;
               end else begin
                  kept   = mant >> 2;
                  guard  = mant[1];
                  sticky = mant[0];
               end
               round_up = guard & (sticky | kept[0]);
               mag      = 31'(kept) + 31'(round_up);
            end
         end

         assign result = DATA_WIDTH'({sign, mag});
      end
   endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin lane arbiter: pointer register plus next-grant search.
// Grants only when the downstream stage can load; pointer moves on accept only.
module rr_arbiter
   import avgpool_div_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQ-1:0]  req_valid,
   input  logic                load_ok,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_id,
   output logic                accept
);

   logic [RR_IDX_W-1:0] last;
   rr_grant_t           pick;

   always_comb begin
      pick     = rr_next_grant(RR_MAX'(req_valid), last, NUM_REQ);
      grant    = '0;
      accept   = 1'b0;
      grant_id = ID_WIDTH'(pick.idx);
      if (pick.hit && load_ok && !reset) begin
         grant[pick.idx] = 1'b1;
         accept          = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last <= RR_IDX_W'(NUM_REQ - 1);
      end else if (accept) begin
         last <= pick.idx;
      end
   end

endmodule

// File: rtl/avgpool_div_arbiter.sv
// Shares one divide-by-4 scaler among NUM_REQ pooling lanes: round-robin accept,
// two registered stages around Divider, result tagged with the issuing lane ID.
module avgpool_div_arbiter
   import avgpool_div_arbiter_pkg::*;
#(
   parameter int ARITH_TYPE = ARITH_FIXED,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   avgpool_div_arbiter_if.slave  bus
);

   logic [NUM_REQ-1:0]           grant_p0;
   logic [ID_WIDTH-1:0]          id_p0;
   logic                         accept_p0;
   logic signed [DATA_WIDTH-1:0] data_p0;

   logic                         vld_p1;
   logic [ID_WIDTH-1:0]          id_p1;
   logic signed [DATA_WIDTH-1:0] data_p1;
   logic [DATA_WIDTH-1:0]        quot_p1;

   logic                         vld_p2;
   logic [ID_WIDTH-1:0]          id_p2;
   logic signed [DATA_WIDTH-1:0] data_p2;

   logic                         ld_p1;
   logic                         ld_p2;
   logic [15:0]                  done_count;

   // A full output stage frees up in the same cycle the consumer takes it.
   assign ld_p2 = !vld_p2 || bus.out_ready;
   assign ld_p1 = !vld_p1 || ld_p2;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_valid (bus.req_valid),
      .load_ok   (ld_p1),
      .grant     (grant_p0),
      .grant_id  (id_p0),
      .accept    (accept_p0)
   );

   assign bus.req_ready = grant_p0;
   assign data_p0       = bus.req_data[int'(id_p0) * DATA_WIDTH +: DATA_WIDTH];

   // ---- p0 -> p1 : accepted operand
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1 <= 1'b0;
      end else if (ld_p1) begin
         vld_p1 <= accept_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_p1 && accept_p0) begin
         data_p1 <= data_p0;
         id_p1   <= id_p0;
      end
   end

   Divider #(
      .ARITH_TYPE (ARITH_TYPE),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_div (
      .operand (data_p1),
      .result  (quot_p1)
   );

   // ---- p1 -> p2 : divided result, held while the consumer stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p2     <= 1'b0;
         data_p2    <= '0;
         id_p2      <= '0;
         done_count <= '0;
      end else begin
         if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               data_p2 <= quot_p1;
               id_p2   <= id_p1;
            end
         end
         if (vld_p2 && bus.out_ready) begin
            done_count <= done_count + 16'd1;
         end
      end
   end

   assign bus.out_valid  = vld_p2;
   assign bus.out_data   = data_p2;
   assign bus.out_id     = id_p2;
   assign bus.done_count = done_count;

endmodule

// File: tb/tb_avgpool_div_arbiter.sv
// Directed-plus-random bench: a fixed-point and a float instance see identical traffic,
// checked against an elastic-buffer reference model with round-robin grant prediction.
module tb_avgpool_div_arbiter;
   import avgpool_div_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   typedef struct {
      logic [31:0] op;
      int          lane;
      int          cyc;
      bit          fv;
      logic [31:0] fe;
   } ent_t;

   logic clk;
   logic reset;

   avgpool_div_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus_fx ();
   avgpool_div_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus_fp ();

   avgpool_div_arbiter #(.ARITH_TYPE(ARITH_FIXED), .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW))
      dut_fx (.clk(clk), .reset(reset), .bus(bus_fx));
   avgpool_div_arbiter #(.ARITH_TYPE(ARITH_FLOAT), .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW))
      dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int          lane_cnt [NR];
   logic [31:0] lane_dat [NR];
   bit          lane_fv  [NR];
   logic [31:0] lane_fe  [NR];

   int          m_last;
   int          m_now;
   int          m_done;
   ent_t        q[$];
   int          obs_ids[$];
   int          pulses [NR];
   int          total_grants;
   logic [31:0] last_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic real fdec(input logic [31:0] b);
      real m;
      int  e;
      e = int'(b[30:23]);
      if (e == 0) begin
         m = real'(b[22:0]);
         e = -149;
      end else begin
         m = real'({1'b1, b[22:0]});
         e = e - 150;
      end
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return b[31] ? -m : m;
   endfunction

   task automatic chkf(input string tag, input logic [31:0] obs, input logic [31:0] op);
      real o_r, e_r;
      o_r = fdec(obs);
      e_r = fdec(op) * 0.25;
      checks++;
      assert (o_r == e_r) else begin
         errors++;
         $error("FAIL %s: observed %h (%g) expected value %g", tag, obs, o_r, e_r);
      end
   endtask

   function automatic logic [31:0] floor_div4(input logic [31:0] v);
      longint x, r;
      x = longint'($signed(v));
      r = x / 4;
      if ((x % 4) != 0 && x < 0) r = r - 1;
      return r[31:0];
   endfunction

   function automatic int exp_pick(input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         int j;
         j = (m_last + k) % NR;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      m_last = NR - 1;
      m_done = 0;
   endtask

   task automatic load_lane(input int l, input logic [31:0] d, input bit fv, input logic [31:0] fe);
      lane_cnt[l] = 1;
      lane_dat[l] = d;
      lane_fv[l]  = fv;
      lane_fe[l]  = fe;
   endtask

   // One clock: drive lanes, sample at posedge+2, advance the model, wait to posedge+1.
   task automatic cycle(input logic ordy);
      logic [NR-1:0]    vld;
      logic [NR*DW-1:0] dat;
      logic [31:0]      exp_rdy;
      int               g;
      bit               ev;
      ent_t             e;
      ent_t             h;
      for (int i = 0; i < NR; i++) begin
         vld[i] = lane_cnt[i] > 0;
         dat[i*DW +: DW] = lane_dat[i];
      end
      bus_fx.req_valid = vld; bus_fx.req_data = dat; bus_fx.out_ready = ordy;
      bus_fp.req_valid = vld; bus_fp.req_data = dat; bus_fp.out_ready = ordy;
      #1;
      g = (q.size() < 2 || ordy) ? exp_pick(vld) : -1;
      exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
      last_rdy = 32'(bus_fx.req_ready);
      chk("fx_req_ready", 32'(bus_fx.req_ready), exp_rdy);
      chk("fp_req_ready", 32'(bus_fp.req_ready), exp_rdy);
      for (int i = 0; i < NR; i++) pulses[i] += int'(bus_fx.req_ready[i]);
      ev = (q.size() > 0) && (q[0].cyc + 2 <= m_now);
      chk("fx_out_valid", 32'(bus_fx.out_valid), 32'(ev));
      chk("fp_out_valid", 32'(bus_fp.out_valid), 32'(ev));
      if (ev) begin
         h = q[0];
         chk("fx_out_id", 32'(bus_fx.out_id), 32'(h.lane));
         chk("fp_out_id", 32'(bus_fp.out_id), 32'(h.lane));
         chk("fx_out_data", bus_fx.out_data, floor_div4(h.op));
         if (h.fv) chk("fp_out_data_exact", bus_fp.out_data, h.fe);
         else if (h.op[30:23] >= 8'd3 && h.op[30:23] <= 8'd254) chkf("fp_out_data", bus_fp.out_data, h.op);
         if (ordy) obs_ids.push_back(int'(bus_fx.out_id));
      end
      chk("fx_done_count", 32'(bus_fx.done_count), 32'(m_done & 16'hFFFF));
      chk("fp_done_count", 32'(bus_fp.done_count), 32'(m_done & 16'hFFFF));
      if (ev && ordy) begin
         void'(q.pop_front());
         m_done++;
      end
      if (g >= 0) begin
         e.op = lane_dat[g]; e.lane = g; e.cyc = m_now; e.fv = lane_fv[g]; e.fe = lane_fe[g];
         q.push_back(e);
         m_last = g;
         total_grants++;
         lane_cnt[g]--;
         lane_dat[g] = $urandom;
         lane_fv[g]  = 1'b0;
      end
      m_now++;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] held_data;
   logic [31:0] held_id;
   int          acc_before;
   logic [31:0] dn_ops [6];
   logic [31:0] dn_exp [6];

   initial begin
      m_now = 0;
      total_grants = 0;
      for (int i = 0; i < NR; i++) begin
         lane_cnt[i] = 0; lane_dat[i] = '0; lane_fv[i] = 1'b0; lane_fe[i] = '0; pulses[i] = 0;
      end
      model_reset();

      // Reset state with every lane requesting: nothing may be granted.
      reset = 1'b1;
      bus_fx.req_valid = '1; bus_fx.req_data = '0; bus_fx.out_ready = 1'b1;
      bus_fp.req_valid = '1; bus_fp.req_data = '0; bus_fp.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus_fx.req_ready), 32'd0);
      chk("rst_out_valid", 32'(bus_fx.out_valid), 32'd0);
      chk("rst_out_data", bus_fx.out_data, 32'd0);
      chk("rst_out_id", 32'(bus_fx.out_id), 32'd0);
      chk("rst_done_count", 32'(bus_fx.done_count), 32'd0);
      reset = 1'b0;

      // All lanes valid for 8 grants: rotation 0,1,2,3,0,1,2,3.
      for (int i = 0; i < NR; i++) lane_cnt[i] = 2;
      obs_ids.delete();
      repeat (8) cycle(1'b1);
      repeat (3) cycle(1'b1);
      chk("burst_len", 32'(obs_ids.size()), 32'd8);
      for (int k = 0; k < 8 && k < obs_ids.size(); k++) chk("burst_id_seq", 32'(obs_ids[k]), 32'(k % NR));
      for (int i = 0; i < NR; i++) chk("burst_pulses", 32'(pulses[i]), 32'd2);

      // Lane 2 alone sends 0x40; then -3 on lane 0 and 4.0 on lane 1.
      load_lane(2, 32'h00000040, 1'b1, 32'h00000010);
      cycle(1'b1);
      repeat (3) cycle(1'b1);
      chk("single_done", 32'(bus_fx.done_count), 32'd9);
      load_lane(0, 32'hFFFFFFFD, 1'b0, 32'h0);
      cycle(1'b1);
      load_lane(1, 32'h40800000, 1'b1, 32'h3F800000);
      cycle(1'b1);
      repeat (3) cycle(1'b1);

      // Float subnormal results, including the tie that rounds up to the min normal.
      dn_ops[0] = 32'h00000006; dn_exp[0] = 32'h00000002;
      dn_ops[1] = 32'h00000005; dn_exp[1] = 32'h00000001;
      dn_ops[2] = 32'h00800001; dn_exp[2] = 32'h00200000;
      dn_ops[3] = 32'h01000000; dn_exp[3] = 32'h00400000;
      dn_ops[4] = 32'h017FFFFF; dn_exp[4] = 32'h00800000;
      dn_ops[5] = 32'h81800000; dn_exp[5] = 32'h80800000;
      for (int k = 0; k < 6; k++) begin
         load_lane(3, dn_ops[k], 1'b1, dn_exp[k]);
         cycle(1'b1);
      end
      repeat (3) cycle(1'b1);

      // Backpressure: out_ready low for 5 cycles during a burst.
      for (int i = 0; i < NR; i++) lane_cnt[i] = 2;
      acc_before = total_grants;
      cycle(1'b0);
      cycle(1'b0);
      held_data = bus_fx.out_data;
      held_id   = 32'(bus_fx.out_id);
      chk("stall_first_valid", 32'(bus_fx.out_valid), 32'd1);
      repeat (3) begin
         cycle(1'b0);
         chk("stall_hold_data", bus_fx.out_data, held_data);
         chk("stall_hold_id", 32'(bus_fx.out_id), held_id);
      end
      chk("stall_accepts", 32'(total_grants - acc_before), 32'd2);
      repeat (12) cycle(1'b1);
      chk("stall_drained", 32'(bus_fx.done_count), 32'(m_done));

      // Random traffic: lane loads, pre-grant drops and consumer backpressure.
      for (int t = 0; t < 300; t++) begin
         for (int i = 0; i < NR; i++) begin
            if (lane_cnt[i] == 0 && $urandom_range(0, 3) == 0) begin
               lane_cnt[i] = int'($urandom_range(1, 3));
               lane_dat[i] = ($urandom_range(0, 3) == 0) ? -($urandom_range(0, 64)) : $urandom;
            end else if (lane_cnt[i] > 0 && $urandom_range(0, 15) == 0) begin
               lane_cnt[i] = 0;
            end
         end
         cycle($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < NR; i++) lane_cnt[i] = 0;
      repeat (4) cycle(1'b1);

      // Asynchronous reset with two results in flight.
      for (int i = 0; i < NR; i++) lane_cnt[i] = 3;
      repeat (3) cycle(1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(bus_fx.out_valid), 32'd0);
      chk("async_rst_req_ready", 32'(bus_fx.req_ready), 32'd0);
      chk("async_rst_fp_out_valid", 32'(bus_fp.out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("async_rst_hold_valid", 32'(bus_fx.out_valid), 32'd0);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < NR; i++) lane_cnt[i] = 1;
      cycle(1'b1);
      chk("first_grant_after_reset", last_rdy, 32'd1);
      chk("done_after_reset", 32'(bus_fx.done_count), 32'd0);
      repeat (6) cycle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
